// File: rtl/acq_clk_gen_pkg.sv
// acq_clk_pkg: shared definitions for the acquisition clock generator.
//   acq_state_e      mode FSM states, encoded as mode_state (IDLE=0, LOAD=1, READ=2)
//   MODE_LOAD/READ   mode_req encodings
//   acq_ch_width     ch_idx width, never below 1
//   acq_params_ok    parameter-legality check evaluated at elaboration
package acq_clk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_READ = 2'd2
  } acq_state_e;

  localparam logic MODE_LOAD = 1'b1;
  localparam logic MODE_READ = 1'b0;

  function automatic int acq_ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic bit acq_params_ok(input int fdata_half, input int load_period,
                                       input int load_high, input int read_period,
                                       input int adc_skew, input int num_ch);
    return (fdata_half >= 2) &&
           (load_period >= 2) &&
           (load_high >= 1) && (load_high < load_period) &&
           (read_period >= 4) && ((read_period % 2) == 0) &&
           (adc_skew >= 0) && (adc_skew < read_period / 2) &&
           (num_ch >= 1);
  endfunction

endpackage

// File: rtl/acq_clk_gen_if.sv
// acq_clk_gen_if: control and phase-output bundle of the acquisition clock generator.
//   en, mode_req         gate enable and requested mode (1 = LOAD, 0 = READ)
//   fdata                free-running bit clock
//   load, read, fch,     gated phase signals
//   fadc
//   mode_state, mode_ack current FSM state and state-change pulse
//   ch_idx, frame_strobe channel index and channel-sweep wrap pulse
// master: the controller that drives en/mode_req. slave: the generator.
interface acq_clk_gen_if #(
  parameter int CH_W = 3
);
  logic            en;
  logic            mode_req;
  logic            fdata;
  logic            load;
  logic            read;
  logic            fch;
  logic            fadc;
  logic [1:0]      mode_state;
  logic            mode_ack;
  logic [CH_W-1:0] ch_idx;
  logic            frame_strobe;

  modport master (
    output en, mode_req,
    input  fdata, load, read, fch, fadc, mode_state, mode_ack, ch_idx, frame_strobe
  );

  modport slave (
    input  en, mode_req,
    output fdata, load, read, fch, fadc, mode_state, mode_ack, ch_idx, frame_strobe
  );
endinterface

// File: rtl/acq_clk_gen_phase_ctr.sv
// acq_phase_ctr: wrapping phase counter, 0..period-1, advanced on tick.
//   clk, rst  clock and synchronous active-high reset
//   tick      advance enable
//   clr       force the counter to 0 (overrides tick)
//   period    wrap length
//   count     value the counter takes on this edge, so registered decoders
//             downstream line up with the counter without extra latency
//   wrap      tick on which the counter goes from period-1 to 0
module acq_phase_ctr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         clr,
  input  logic [W-1:0] period,
  output logic [W-1:0] count,
  output logic         wrap
);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;

  assign wrap = tick && (cnt_q == period - ONE);

  always_comb begin
    count = cnt_q;
    if (clr || wrap) begin
      count = '0;
    end else if (tick) begin
      count = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= count;
    end
  end
endmodule

// File: rtl/acq_clk_gen.sv
// acq_clk_gen: acquisition clock generator for the ear-EEG front-end.
// Produces the fdata bit clock and the LOAD/READ framed phase signals, all
// registered in the sys_clk domain.
//   sys_clk  system clock
//   rst      synchronous active-high reset
//   bus      acq_clk_gen_if.slave: en, mode_req in; fdata, load, read, fch,
//            fadc, mode_state, mode_ack, ch_idx, frame_strobe out
// Build option: ACQ_CLKGEN_ADC_SKEW_EN delays the fadc rise by ADC_SKEW fdata
// periods after fch; without it fadc follows fch exactly.
module acq_clk_gen
  import acq_clk_pkg::*;
#(
  parameter int FDATA_HALF  = 98,
  parameter int LOAD_PERIOD = 8,
  parameter int LOAD_HIGH   = 1,
  parameter int READ_PERIOD = 16,
  parameter int ADC_SKEW    = 0,
  parameter int NUM_CH      = 8,
  parameter int CH_W        = acq_ch_width(NUM_CH)
) (
  input logic          sys_clk,
  input logic          rst,
  acq_clk_gen_if.slave bus
);

  if (!acq_params_ok(FDATA_HALF, LOAD_PERIOD, LOAD_HIGH, READ_PERIOD, ADC_SKEW, NUM_CH))
  begin : g_bad_params
    $error("acq_clk_gen: illegal parameter combination");
  end

  localparam int HC_W  = $clog2(FDATA_HALF);
  localparam int PH_MX = (LOAD_PERIOD > READ_PERIOD) ? LOAD_PERIOD : READ_PERIOD;
  localparam int PH_W  = $clog2(PH_MX + 1);

  localparam logic [HC_W-1:0] HC_LAST  = HC_W'(FDATA_HALF - 1);
  localparam logic [HC_W-1:0] HC_ONE   = HC_W'(1);
  localparam logic [PH_W-1:0] LOAD_P   = PH_W'(LOAD_PERIOD);
  localparam logic [PH_W-1:0] READ_P   = PH_W'(READ_PERIOD);
  localparam logic [PH_W-1:0] LOAD_ON  = PH_W'(LOAD_PERIOD - LOAD_HIGH);
  localparam logic [PH_W-1:0] READ_MID = PH_W'(READ_PERIOD / 2);
  localparam logic [CH_W-1:0] CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0] CH_ONE   = CH_W'(1);
`ifdef ACQ_CLKGEN_ADC_SKEW_EN
  localparam logic [PH_W-1:0] ADC_ON   = PH_W'(READ_PERIOD / 2 + ADC_SKEW);
`endif

  logic [HC_W-1:0] hc;
  logic            fdata_q;
  logic            tick;

  acq_state_e      state_q, state_n;
  logic            clr;
  logic            wrap;
  logic [PH_W-1:0] period;
  logic [PH_W-1:0] ph_n;

  logic            load_q, read_q, fch_q, fadc_q, ack_q, strobe_q;
  logic            load_n, read_n, fch_n, fadc_n, ack_n, strobe_n;
  logic [CH_W-1:0] ch_q, ch_n;

  // Tick marks the edge on which fdata falls.
  assign tick = (hc == HC_LAST) && fdata_q;

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: begin
        if (tick && bus.en) begin
          state_n = (bus.mode_req == MODE_LOAD) ? ST_LOAD : ST_READ;
        end
      end
      ST_LOAD, ST_READ: begin
        if (wrap) begin
          if (!bus.en) begin
            state_n = ST_IDLE;
          end else if (bus.mode_req == MODE_LOAD) begin
            state_n = ST_LOAD;
          end else begin
            state_n = ST_READ;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Phase is parked at 0 in IDLE and restarts at 0 on every state entry.
  assign clr    = (state_q == ST_IDLE) || (state_n != state_q);
  assign period = (state_q == ST_LOAD) ? LOAD_P : READ_P;

  acq_phase_ctr #(
    .W (PH_W)
  ) u_ph (
    .clk    (sys_clk),
    .rst    (rst),
    .tick   (tick),
    .clr    (clr),
    .period (period),
    .count  (ph_n),
    .wrap   (wrap)
  );

  // Outputs are decoded from the post-edge state and phase, then registered,
  // so they change on the very edge where fdata falls.
  always_comb begin
    load_n = 1'b0;
    read_n = 1'b0;
    fch_n  = 1'b0;
    fadc_n = 1'b0;
    case (state_n)
      ST_LOAD: load_n = (ph_n >= LOAD_ON);
      ST_READ: begin
        fch_n  = (ph_n >= READ_MID);
        read_n = (ph_n == READ_MID);
`ifdef ACQ_CLKGEN_ADC_SKEW_EN
        fadc_n = (ph_n >= ADC_ON);
`else
        fadc_n = fch_n;
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    ch_n     = ch_q;
    strobe_n = 1'b0;
    if (state_n != ST_READ) begin
      ch_n = '0;
    end else if ((state_q == ST_READ) && wrap) begin
      if (ch_q == CH_LAST) begin
        ch_n     = '0;
        strobe_n = 1'b1;
      end else begin
        ch_n = ch_q + CH_ONE;
      end
    end
  end

  assign ack_n = (state_n != state_q);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      hc       <= '0;
      fdata_q  <= 1'b0;
      state_q  <= ST_IDLE;
      load_q   <= 1'b0;
      read_q   <= 1'b0;
      fch_q    <= 1'b0;
      fadc_q   <= 1'b0;
      ack_q    <= 1'b0;
      strobe_q <= 1'b0;
      ch_q     <= '0;
    end else begin
      if (hc == HC_LAST) begin
        hc      <= '0;
        fdata_q <= ~fdata_q;
      end else begin
        hc <= hc + HC_ONE;
      end
      state_q  <= state_n;
      load_q   <= load_n;
      read_q   <= read_n;
      fch_q    <= fch_n;
      fadc_q   <= fadc_n;
      ack_q    <= ack_n;
      strobe_q <= strobe_n;
      ch_q     <= ch_n;
    end
  end

  assign bus.fdata        = fdata_q;
  assign bus.load         = load_q;
  assign bus.read         = read_q;
  assign bus.fch          = fch_q;
  assign bus.fadc         = fadc_q;
  assign bus.mode_state   = state_q;
  assign bus.mode_ack     = ack_q;
  assign bus.ch_idx       = ch_q;
  assign bus.frame_strobe = strobe_q;

endmodule

// File: tb/tb_acq_clk_gen.sv
// tb_acq_clk_gen: directed, table-driven bench for acq_clk_gen with the
// default framing (FDATA_HALF=98, LOAD 8/1, READ 16, 8 channels) and
// ADC_SKEW=2, so the fadc expectation depends on ACQ_CLKGEN_ADC_SKEW_EN.
module tb_acq_clk_gen;
  import acq_clk_pkg::*;

  localparam int FH   = 98;
  localparam int LP   = 8;
  localparam int LH   = 1;
  localparam int RP   = 16;
  localparam int SKEW = 2;
  localparam int NCH  = 8;
  localparam int CHW  = 3;
`ifdef ACQ_CLKGEN_ADC_SKEW_EN
  localparam bit SKEW_ON = 1'b1;
`else
  localparam bit SKEW_ON = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;

  acq_clk_gen_if #(.CH_W(CHW)) bus ();

  acq_clk_gen #(
    .FDATA_HALF  (FH),
    .LOAD_PERIOD (LP),
    .LOAD_HIGH   (LH),
    .READ_PERIOD (RP),
    .ADC_SKEW    (SKEW),
    .NUM_CH      (NCH),
    .CH_W        (CHW)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;
  int overlap  = 0;

  always @(negedge sys_clk) begin
    if (!rst && bus.load && bus.read) overlap++;
  end

  initial begin
    #100000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // {mode_state, load, read, fch, fadc, ch_idx, mode_ack, frame_strobe}
  function automatic int pack(input logic [1:0] st, input logic ld, input logic rd,
                              input logic fc, input logic fa, input logic [2:0] ch,
                              input logic ack, input logic fs);
    logic [10:0] v;
    v = {st, ld, rd, fc, fa, ch, ack, fs};
    return int'(v);
  endfunction

  function automatic int outs();
    logic [10:0] v;
    v = {bus.mode_state, bus.load, bus.read, bus.fch, bus.fadc, bus.ch_idx,
         bus.mode_ack, bus.frame_strobe};
    return int'(v);
  endfunction

  // Advance to #1 after the next edge on which fdata falls.
  task automatic next_tick();
    logic prev;
    for (int n = 0; n < 4 * FH; n++) begin
      prev = bus.fdata;
      @(posedge sys_clk);
      #1;
      if (prev && !bus.fdata) return;
    end
    chk("tick_timeout", 1, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) next_tick();
  endtask

  typedef struct {
    logic en;
    logic req;
    int   adv;
    int   exp;
  } vec_t;

  vec_t vt[17];

  initial begin
    int   rise, fall, gated;
    int   ld_cnt, other_cnt;
    logic fa_mid;

    fa_mid = !SKEW_ON;  // fadc at ph 8 and 9 of a READ frame

    vt[0]  = '{1'b0, 1'b1, 1,  pack(ST_IDLE, 0, 0, 0, 0,      0, 0, 0)};
    vt[1]  = '{1'b1, 1'b1, 1,  pack(ST_LOAD, 0, 0, 0, 0,      0, 1, 0)};
    vt[2]  = '{1'b1, 1'b1, 6,  pack(ST_LOAD, 0, 0, 0, 0,      0, 0, 0)};
    vt[3]  = '{1'b1, 1'b1, 1,  pack(ST_LOAD, 1, 0, 0, 0,      0, 0, 0)};
    vt[4]  = '{1'b1, 1'b0, 1,  pack(ST_READ, 0, 0, 0, 0,      0, 1, 0)};
    vt[5]  = '{1'b1, 1'b0, 7,  pack(ST_READ, 0, 0, 0, 0,      0, 0, 0)};
    vt[6]  = '{1'b1, 1'b0, 1,  pack(ST_READ, 0, 1, 1, fa_mid, 0, 0, 0)};
    vt[7]  = '{1'b1, 1'b0, 1,  pack(ST_READ, 0, 0, 1, fa_mid, 0, 0, 0)};
    vt[8]  = '{1'b1, 1'b0, 1,  pack(ST_READ, 0, 0, 1, 1,      0, 0, 0)};
    vt[9]  = '{1'b1, 1'b0, 5,  pack(ST_READ, 0, 0, 1, 1,      0, 0, 0)};
    vt[10] = '{1'b1, 1'b0, 1,  pack(ST_READ, 0, 0, 0, 0,      1, 0, 0)};
    vt[11] = '{1'b0, 1'b0, 8,  pack(ST_READ, 0, 1, 1, fa_mid, 1, 0, 0)};
    vt[12] = '{1'b0, 1'b0, 8,  pack(ST_IDLE, 0, 0, 0, 0,      0, 1, 0)};
    vt[13] = '{1'b0, 1'b0, 1,  pack(ST_IDLE, 0, 0, 0, 0,      0, 0, 0)};
    vt[14] = '{1'b1, 1'b0, 1,  pack(ST_READ, 0, 0, 0, 0,      0, 1, 0)};
    vt[15] = '{1'b0, 1'b1, 16, pack(ST_IDLE, 0, 0, 0, 0,      0, 1, 0)};
    vt[16] = '{1'b0, 1'b1, 1,  pack(ST_IDLE, 0, 0, 0, 0,      0, 0, 0)};

    // Reset values and fdata start-up
    bus.en       = 1'b0;
    bus.mode_req = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_outs", outs(), 0);
    chk("reset_fdata", int'(bus.fdata), 0);
    @(negedge sys_clk);
    rst = 1'b0;
    rise = -1;
    fall = -1;
    gated = 0;
    for (int c = 1; c <= 250; c++) begin
      @(posedge sys_clk);
      #1;
      if (bus.fdata && rise < 0) rise = c;
      if (!bus.fdata && rise >= 0 && fall < 0) fall = c;
      if (bus.load || bus.read || bus.fch || bus.fadc) gated++;
      if (fall >= 0) break;
    end
    chk("fdata_first_rise", rise, FH);
    chk("fdata_first_fall", fall, 2 * FH);
    chk("gates_idle_en0", gated, 0);

    // Tick-level vector table
    for (int i = 0; i < 17; i++) begin
      bus.en       = vt[i].en;
      bus.mode_req = vt[i].req;
      ticks(vt[i].adv);
      chk($sformatf("vec%0d", i), outs(), vt[i].exp);
    end

    // READ channel sweep and wrap strobe
    bus.en       = 1'b1;
    bus.mode_req = 1'b0;
    next_tick();
    chk("read_entry", outs(), pack(ST_READ, 0, 0, 0, 0, 0, 1, 0));
    @(posedge sys_clk);
    #1;
    chk("ack_one_cycle", int'(bus.mode_ack), 0);
    for (int f = 0; f < NCH; f++) begin
      ticks(RP);
      chk($sformatf("sweep_ch%0d", f), int'(bus.ch_idx), (f + 1) % NCH);
      chk($sformatf("sweep_strobe%0d", f), int'(bus.frame_strobe), (f == NCH - 1) ? 1 : 0);
    end
    @(posedge sys_clk);
    #1;
    chk("strobe_one_cycle", int'(bus.frame_strobe), 0);

    // Mid-frame switch request at ph 5: READ frame completes before LOAD
    ticks(5);
    bus.mode_req = 1'b1;
    ticks(3);
    chk("switch_ph8", outs(), pack(ST_READ, 0, 1, 1, fa_mid, 0, 0, 0));
    ticks(7);
    chk("switch_ph15", outs(), pack(ST_READ, 0, 0, 1, 1, 0, 0, 0));
    next_tick();
    chk("switch_boundary", outs(), pack(ST_LOAD, 0, 0, 0, 0, 0, 1, 0));

    // Two toggles within a LOAD frame: no switch at the boundary
    ticks(2);
    bus.mode_req = 1'b0;
    ticks(2);
    bus.mode_req = 1'b1;
    ticks(LP - 4);
    chk("double_toggle", outs(), pack(ST_LOAD, 0, 0, 0, 0, 0, 0, 0));

    // LOAD duty over one full frame
    ld_cnt = 0;
    other_cnt = 0;
    for (int c = 0; c < LP * 2 * FH; c++) begin
      @(posedge sys_clk);
      #1;
      if (bus.load) ld_cnt++;
      if (bus.read || bus.fch || bus.fadc) other_cnt++;
    end
    chk("load_high_cycles", ld_cnt, LH * 2 * FH);
    chk("load_other_gates", other_cnt, 0);

    // Reset in the middle of the load pulse
    ticks(LP - 1);
    chk("load_ph7", outs(), pack(ST_LOAD, 1, 0, 0, 0, 0, 0, 0));
    @(negedge sys_clk);
    rst = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("rst_mid_outs", outs(), 0);
    chk("rst_mid_fdata", int'(bus.fdata), 0);

    chk("load_read_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
